// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: opcode encoding, controller states
// and the default datapath width. The ALU uses the same opcode constants.
package alu_arbiter_pkg;

    localparam int W_DEFAULT = 8;

    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_AND     = 3'b010;
    localparam logic [2:0] OP_OR      = 3'b011;
    localparam logic [2:0] OP_XOR     = 3'b100;
    localparam logic [2:0] OP_ILLEGAL = 3'b101;
    localparam logic [2:0] OP_SLT     = 3'b110;
    localparam logic [2:0] OP_BZ      = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True for the one opcode the ALU does not implement.
    function automatic logic is_illegal(input logic [2:0] op);
        return op == OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the result bus and the ALU drive/return
// signals. master = requesters plus ALU, slave = the arbiter itself.
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int W = W_DEFAULT
);
    logic         req0;
    logic         req1;
    logic [2:0]   op0;
    logic [2:0]   op1;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         gnt0;
    logic         gnt1;
    logic         done0;
    logic         done1;
    logic [W-1:0] res;
    logic         zf;
    logic         err;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_ans;
    logic         alu_zero;

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1, alu_ans, alu_zero,
        input  gnt0, gnt1, done0, done1, res, zf, err, alu_op, alu_a, alu_b
    );

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1, alu_ans, alu_zero,
        output gnt0, gnt1, done0, done1, res, zf, err, alu_op, alu_a, alu_b
    );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin picker. On a tie the requester not served last wins;
// the pointer only moves when the caller actually takes the grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       winner
);
    logic last_reg;

    // Pick the sole requester, or the one not served last on a tie.
    always_comb begin
        winner = 1'b0;
        case (req)
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_reg;
            default: winner = 1'b0;
        endcase
    end

    // Remember who was granted; reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= 1'b1;
        end else if (take) begin
            last_reg <= winner;
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: grant round-robin, register the
// winner's opcode/operands onto the ALU, wait ALU_LAT cycles, capture the
// result and pulse the winner's done for one cycle.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int W       = W_DEFAULT,
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT);

    state_t       state_reg;
    logic [2:0]   cnt_reg;
    logic         sel_reg;
    logic         gnt0_reg;
    logic         gnt1_reg;
    logic         done0_reg;
    logic         done1_reg;
    logic [W-1:0] res_reg;
    logic         zf_reg;
    logic         err_reg;
    logic [2:0]   alu_op_reg;
    logic [W-1:0] alu_a_reg;
    logic [W-1:0] alu_b_reg;

    logic         winner;
    logic         take;

    // A grant is taken only from IDLE; requests in EXEC/DONE simply wait.
    assign take = (state_reg == ST_IDLE) && (bus.req0 || bus.req1);

    rr_arb2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    ({bus.req1, bus.req0}),
        .take   (take),
        .winner (winner)
    );

    // Grant / execute / done sequencer with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= 3'd0;
            sel_reg    <= 1'b0;
            gnt0_reg   <= 1'b0;
            gnt1_reg   <= 1'b0;
            done0_reg  <= 1'b0;
            done1_reg  <= 1'b0;
            res_reg    <= '0;
            zf_reg     <= 1'b0;
            err_reg    <= 1'b0;
            alu_op_reg <= OP_ADD;
            alu_a_reg  <= '0;
            alu_b_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (take) begin
                        sel_reg    <= winner;
                        gnt0_reg   <= ~winner;
                        gnt1_reg   <= winner;
                        alu_op_reg <= winner ? bus.op1 : bus.op0;
                        alu_a_reg  <= winner ? bus.a1  : bus.a0;
                        alu_b_reg  <= winner ? bus.b1  : bus.b0;
                        cnt_reg    <= LAT_LOAD;
                        state_reg  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    cnt_reg <= cnt_reg - 3'd1;
                    if (cnt_reg == 3'd1) begin
                        if (is_illegal(alu_op_reg)) begin
                            res_reg <= '0;
                            zf_reg  <= 1'b0;
                            err_reg <= 1'b1;
                        end else if (alu_op_reg == OP_BZ) begin
                            res_reg <= '0;
                            zf_reg  <= bus.alu_zero;
                            err_reg <= 1'b0;
                        end else begin
                            res_reg <= bus.alu_ans;
                            zf_reg  <= (bus.alu_ans == '0);
                            err_reg <= 1'b0;
                        end
                        done0_reg <= ~sel_reg;
                        done1_reg <= sel_reg;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done0_reg <= 1'b0;
                    done1_reg <= 1'b0;
                    gnt0_reg  <= 1'b0;
                    gnt1_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0   = gnt0_reg;
    assign bus.gnt1   = gnt1_reg;
    assign bus.done0  = done0_reg;
    assign bus.done1  = done1_reg;
    assign bus.res    = res_reg;
    assign bus.zf     = zf_reg;
    assign bus.err    = err_reg;
    assign bus.alu_op = alu_op_reg;
    assign bus.alu_a  = alu_a_reg;
    assign bus.alu_b  = alu_b_reg;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with ALU_LAT=1 driven from a
// vector table plus tie/reset sequences, one with ALU_LAT=3 for latency.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.W(8)) if_a ();
    alu_arbiter_if #(.W(8)) if_b ();

    alu_arbiter #(.W(8), .ALU_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    alu_arbiter #(.W(8), .ALU_LAT(3)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    // Reference ALU: {zero, ans}. BZ and the illegal opcode return junk on
    // ans so a capture that wrongly uses it is visible.
    function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        case (op)
            OP_ADD: r = a + b;
            OP_SUB: r = a - b;
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SLT: r = (a < b) ? 8'd1 : 8'd0;
            OP_BZ:  return {(a == 8'd0), 8'h55};
            default: return {1'b1, 8'hAA};
        endcase
        return {(r == 8'd0), r};
    endfunction

    assign {if_a.alu_zero, if_a.alu_ans} = alu_f(if_a.alu_op, if_a.alu_a, if_a.alu_b);

    logic [8:0] pipe_b0, pipe_b1;
    always_ff @(posedge clk) begin
        pipe_b0 <= alu_f(if_b.alu_op, if_b.alu_a, if_b.alu_b);
        pipe_b1 <= pipe_b0;
    end
    assign {if_b.alu_zero, if_b.alu_ans} = pipe_b1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       port;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       zf;
        logic       err;
    } vec_t;

    vec_t vecs[11];

    // Single request on DUT A, starting at a negedge in IDLE; ends in IDLE.
    task automatic run_op(input vec_t v);
        if (!v.port) begin
            if_a.req0 = 1'b1; if_a.op0 = v.op; if_a.a0 = v.a; if_a.b0 = v.b;
        end else begin
            if_a.req1 = 1'b1; if_a.op1 = v.op; if_a.a1 = v.a; if_a.b1 = v.b;
        end
        @(negedge clk);
        chk("grant", {if_a.gnt1, if_a.gnt0}, v.port ? 2'b10 : 2'b01);
        chk("alu_op", if_a.alu_op, v.op);
        chk("done_early", {if_a.done1, if_a.done0}, 2'b00);
        @(negedge clk);
        chk("done", {if_a.done1, if_a.done0}, v.port ? 2'b10 : 2'b01);
        chk("res", if_a.res, v.res);
        chk("zf", if_a.zf, v.zf);
        chk("err", if_a.err, v.err);
        $display("txn port=%0d op=%0d a=%h b=%h res=%h zf=%0b err=%0b",
                 v.port, v.op, v.a, v.b, if_a.res, if_a.zf, if_a.err);
        if_a.req0 = 1'b0;
        if_a.req1 = 1'b0;
        @(negedge clk);
        chk("release", {if_a.gnt1, if_a.gnt0, if_a.done1, if_a.done0}, 4'b0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, OP_ADD,     8'hF0, 8'h20, 8'h10, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, OP_BZ,      8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, OP_BZ,      8'h01, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, OP_ILLEGAL, 8'h03, 8'h04, 8'h00, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, OP_SLT,     8'h03, 8'h07, 8'h01, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, OP_SLT,     8'h07, 8'h03, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, OP_SUB,     8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, OP_AND,     8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, OP_XOR,     8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, OP_ADD,     8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[10] = '{1'b0, OP_OR,      8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};

        rst = 1'b1;
        if_a.req0 = 0; if_a.req1 = 0; if_a.op0 = 0; if_a.op1 = 0;
        if_a.a0 = 0; if_a.b0 = 0; if_a.a1 = 0; if_a.b1 = 0;
        if_b.req0 = 0; if_b.req1 = 0; if_b.op0 = 0; if_b.op1 = 0;
        if_b.a0 = 0; if_b.b0 = 0; if_b.a1 = 0; if_b.b1 = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        chk("rst_gnt",  {if_a.gnt1, if_a.gnt0}, 2'b00);
        chk("rst_done", {if_a.done1, if_a.done0}, 2'b00);
        chk("rst_res",  if_a.res, 8'h00);
        chk("rst_flags", {if_a.zf, if_a.err}, 2'b00);
        chk("rst_alu",  {if_a.alu_op, if_a.alu_a, if_a.alu_b}, 19'd0);
        $display("txn reset state gnt=%b%b res=%h", if_a.gnt1, if_a.gnt0, if_a.res);

        // Both request SUB together and stay high: grants go 0,1,0,1.
        if_a.req0 = 1'b1; if_a.op0 = OP_SUB; if_a.a0 = 8'd9; if_a.b0 = 8'd4;
        if_a.req1 = 1'b1; if_a.op1 = OP_SUB; if_a.a1 = 8'd5; if_a.b1 = 8'd5;
        for (int i = 0; i < 4; i++) begin
            logic w;
            w = i[0];
            @(negedge clk);
            chk("tie_grant", {if_a.gnt1, if_a.gnt0}, w ? 2'b10 : 2'b01);
            @(negedge clk);
            chk("tie_done", {if_a.done1, if_a.done0}, w ? 2'b10 : 2'b01);
            chk("tie_res", if_a.res, w ? 8'h00 : 8'h05);
            chk("tie_zf", if_a.zf, w);
            $display("txn tie round=%0d winner=%0d res=%h zf=%0b", i, w, if_a.res, if_a.zf);
            if (i == 3) begin
                if_a.req0 = 1'b0;
                if_a.req1 = 1'b0;
            end
            @(negedge clk);
            chk("tie_gap", {if_a.gnt1, if_a.gnt0}, 2'b00);
        end

        // Table-driven single requests.
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i]);
        end

        // Reset during EXEC discards the op.
        if_a.req0 = 1'b1; if_a.op0 = OP_ADD; if_a.a0 = 8'd1; if_a.b0 = 8'd1;
        @(negedge clk);
        chk("rst_mid_grant", if_a.gnt0, 1'b1);
        #2;
        rst = 1'b1;
        if_a.req0 = 1'b0;
        #1;
        chk("rst_mid_gnt",  {if_a.gnt1, if_a.gnt0, if_a.done1, if_a.done0}, 4'b0000);
        chk("rst_mid_res",  if_a.res, 8'h00);
        chk("rst_mid_alu",  {if_a.alu_op, if_a.alu_a, if_a.alu_b}, 19'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (4) begin
                @(negedge clk);
                if (if_a.done0 || if_a.done1 || if_a.gnt0 || if_a.gnt1) seen++;
            end
            chk("no_done_after_rst", seen, 0);
            $display("txn reset mid-op activity=%0d", seen);
        end
        begin
            vec_t v;
            v = '{1'b0, OP_ADD, 8'h02, 8'h03, 8'h05, 1'b0, 1'b0};
            run_op(v);
        end

        // ALU_LAT=3 on DUT B: operands changed after grant are ignored.
        if_b.req1 = 1'b1; if_b.op1 = OP_ADD; if_b.a1 = 8'd10; if_b.b1 = 8'd20;
        @(negedge clk);
        chk("l3_grant", {if_b.gnt1, if_b.gnt0}, 2'b10);
        chk("l3_alu_a", if_b.alu_a, 8'd10);
        if_b.a1 = 8'd99; if_b.b1 = 8'd1;
        @(negedge clk);
        chk("l3_done_e1", {if_b.done1, if_b.done0}, 2'b00);
        @(negedge clk);
        chk("l3_done_e2", {if_b.done1, if_b.done0}, 2'b00);
        chk("l3_alu_hold", {if_b.alu_a, if_b.alu_b}, {8'd10, 8'd20});
        chk("l3_gnt_hold", {if_b.gnt1, if_b.gnt0}, 2'b10);
        @(negedge clk);
        chk("l3_done", {if_b.done1, if_b.done0}, 2'b10);
        chk("l3_res", if_b.res, 8'd30);
        chk("l3_flags", {if_b.zf, if_b.err}, 2'b00);
        $display("txn lat3 port=1 res=%h zf=%0b err=%0b", if_b.res, if_b.zf, if_b.err);
        if_b.req1 = 1'b0;
        @(negedge clk);
        chk("l3_release", {if_b.gnt1, if_b.gnt0, if_b.done1, if_b.done0}, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
